// File: rtl/dms_cdr_pkg.sv
// Shared CDR types and constants: millivolt codes, VCO gain-LUT geometry, lock states.
package dms_cdr_pkg;

    typedef logic [10:0] mv_t;
    typedef logic [7:0]  lut_idx_t;

    localparam int LUT_ENTRIES = 161;
    localparam int LUT_STEP_MV = 10;
    localparam int LUT_TOP_MV  = 2000;
    localparam int LUT_RECIP   = 6554;
    localparam int LUT_SHIFT   = 16;

    typedef enum logic {ACQUIRE, TRACK} lock_state_e;

    // 6554/2^16 approximates 1/LUT_STEP_MV; exact for offsets up to 1999,
    // and the -1 bias puts decade ties on the higher-voltage entry.
    function automatic lut_idx_t lut_index(input mv_t v);
        logic signed [12:0] x;
        logic [24:0]        p;
        logic [8:0]         q;
        x = 13'(LUT_TOP_MV - 1) - $signed({2'b00, v});
        if (x < 0) begin
            return '0;
        end
        p = {12'b0, x} * 25'(LUT_RECIP);
        q = 9'(p >> LUT_SHIFT);
        if (q > 9'(LUT_ENTRIES - 1)) begin
            return lut_idx_t'(LUT_ENTRIES - 1);
        end
        return q[7:0];
    endfunction

endpackage

// File: rtl/dms_lock_det.sv
// Lock detector: tracks an anchor voltage and declares lock after enough in-window updates.
module dms_lock_det
    import dms_cdr_pkg::*;
#(
    parameter int VINIT_MV    = 1200,
    parameter int LOCK_WIN_MV = 25,
    parameter int LOCK_CNT    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic upd,
    input  mv_t  v,
    output logic locked
);

    localparam int CW = $clog2(LOCK_CNT + 1);

    lock_state_e   state;
    mv_t           anchor;
    mv_t           d;
    logic [CW-1:0] cnt;
    logic          in_win;

    always_comb begin
        d      = (v > anchor) ? (v - anchor) : (anchor - v);
        in_win = (d <= 11'(LOCK_WIN_MV));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ACQUIRE;
            anchor <= mv_t'(VINIT_MV);
            cnt    <= '0;
            locked <= 1'b0;
        end else if (upd) begin
            case (state)
                ACQUIRE: begin
                    if (in_win) begin
                        if (cnt != CW'(LOCK_CNT)) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (cnt >= CW'(LOCK_CNT - 1)) begin
                            state  <= TRACK;
                            locked <= 1'b1;
                        end
                    end else begin
                        anchor <= v;
                        cnt    <= '0;
                    end
                end
                TRACK: begin
                    if (!in_win) begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                        anchor <= v;
                        cnt    <= '0;
                    end
                end
                default: begin
                    state  <= ACQUIRE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dms_loop_filter.sv
// PI loop filter for the CDR: UP/DN decisions in, clamped VCO control voltage and LUT index out.
module dms_loop_filter
    import dms_cdr_pkg::*;
#(
    parameter int VMIN_MV     = 400,
    parameter int VMAX_MV     = 2000,
    parameter int VINIT_MV    = 1200,
    parameter int KP_MV       = 20,
    parameter int KI          = 64,
    parameter int FRAC        = 8,
    parameter int LOCK_WIN_MV = 25,
    parameter int LOCK_CNT    = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     pd_valid,
    input  logic     pd_up,
    input  logic     pd_dn,
    input  logic     freeze,
    output mv_t      vctrl_mv,
    output logic     vctrl_valid,
    output lut_idx_t lut_idx,
    output logic     idx_valid,
    output logic     locked
);

    localparam int IW = 11 + FRAC + 2;
    localparam int SW = IW + 1;
    localparam int VW = 14;

    logic signed [IW-1:0] integ;
    logic signed [IW-1:0] integ_next;
    logic signed [SW-1:0] isum;
    logic signed [VW-1:0] vsum;
    logic signed [1:0]    err;
    logic                 upd;
    mv_t                  v_upd;

    // Integrator saturates before the proportional term is added (anti-windup).
    always_comb begin
        upd  = pd_valid & ~freeze;
        err  = $signed({1'b0, pd_up}) - $signed({1'b0, pd_dn});
        isum = SW'(integ) + SW'(err) * SW'(KI);
        if (isum > SW'(VMAX_MV << FRAC)) begin
            integ_next = IW'(VMAX_MV << FRAC);
        end else if (isum < SW'(VMIN_MV << FRAC)) begin
            integ_next = IW'(VMIN_MV << FRAC);
        end else begin
            integ_next = IW'(isum);
        end
        vsum = VW'(integ_next >>> FRAC) + VW'(err) * VW'(KP_MV);
        if (vsum > VW'(VMAX_MV)) begin
            v_upd = mv_t'(VMAX_MV);
        end else if (vsum < VW'(VMIN_MV)) begin
            v_upd = mv_t'(VMIN_MV);
        end else begin
            v_upd = mv_t'(vsum);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ       <= IW'(VINIT_MV << FRAC);
            vctrl_mv    <= mv_t'(VINIT_MV);
            vctrl_valid <= 1'b0;
            lut_idx     <= lut_index(mv_t'(VINIT_MV));
            idx_valid   <= 1'b0;
        end else begin
            vctrl_valid <= upd;
            idx_valid   <= vctrl_valid;
            if (upd) begin
                integ    <= integ_next;
                vctrl_mv <= v_upd;
            end
            if (vctrl_valid) begin
                lut_idx <= lut_index(vctrl_mv);
            end
        end
    end

    dms_lock_det #(
        .VINIT_MV    (VINIT_MV),
        .LOCK_WIN_MV (LOCK_WIN_MV),
        .LOCK_CNT    (LOCK_CNT)
    ) u_lock_det (
        .clk    (clk),
        .rst    (rst),
        .upd    (upd),
        .v      (v_upd),
        .locked (locked)
    );

endmodule

// File: tb/tb_dms_loop_filter.sv
// Directed self-checking bench for dms_loop_filter with hand-computed expectations.
module tb_dms_loop_filter;

    logic        clk;
    logic        rst;
    logic        pd_valid;
    logic        pd_up;
    logic        pd_dn;
    logic        freeze;
    logic [10:0] vctrl_mv;
    logic        vctrl_valid;
    logic [7:0]  lut_idx;
    logic        idx_valid;
    logic        locked;

    int checks = 0;
    int errors = 0;

    dms_loop_filter dut (
        .clk         (clk),
        .rst         (rst),
        .pd_valid    (pd_valid),
        .pd_up       (pd_up),
        .pd_dn       (pd_dn),
        .freeze      (freeze),
        .vctrl_mv    (vctrl_mv),
        .vctrl_valid (vctrl_valid),
        .lut_idx     (lut_idx),
        .idx_valid   (idx_valid),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic u, input logic d, input logic f);
        pd_valid = v;
        pd_up    = u;
        pd_dn    = d;
        freeze   = f;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state
        chk("rst_vctrl", 32'(vctrl_mv), 32'd1200);
        chk("rst_idx", 32'(lut_idx), 32'd79);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_vvalid", 32'(vctrl_valid), 32'd0);
        chk("rst_ivalid", 32'(idx_valid), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("idle_vvalid", 32'(vctrl_valid), 32'd0);
        chk("idle_vctrl", 32'(vctrl_mv), 32'd1200);

        // Single up, then up=dn (err=0 but still an update)
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("up1_vctrl", 32'(vctrl_mv), 32'd1220);
        chk("up1_vvalid", 32'(vctrl_valid), 32'd1);
        chk("up1_ivalid", 32'(idx_valid), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ud_vctrl", 32'(vctrl_mv), 32'd1200);
        chk("ud_vvalid", 32'(vctrl_valid), 32'd1);
        chk("up1_idx", 32'(lut_idx), 32'd77);
        chk("up1_ivalid2", 32'(idx_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ud_vvalid_off", 32'(vctrl_valid), 32'd0);
        chk("ud_idx", 32'(lut_idx), 32'd79);
        chk("ud_ivalid", 32'(idx_valid), 32'd1);
        tick();
        chk("ivalid_off", 32'(idx_valid), 32'd0);

        // Lock acquisition from reset with err=0 updates
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++) tick();
        chk("lock_31", 32'(locked), 32'd0);
        tick();
        chk("lock_32", 32'(locked), 32'd1);
        chk("lock_32_vvalid", 32'(vctrl_valid), 32'd1);

        // Ups creep integ by 0.25 mV each: 23 ups give v=1225 (d=25), 24th gives 1226
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 23; i++) tick();
        chk("track_1225_v", 32'(vctrl_mv), 32'd1225);
        chk("track_1225_lock", 32'(locked), 32'd1);
        tick();
        chk("unlock_v", 32'(vctrl_mv), 32'd1226);
        chk("unlock_lock", 32'(locked), 32'd0);

        // Freeze: in-flight idx completes, everything else holds
        tick();
        chk("pre_frz_v", 32'(vctrl_mv), 32'd1226);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("frz_vvalid", 32'(vctrl_valid), 32'd0);
        chk("frz_inflight_ivalid", 32'(idx_valid), 32'd1);
        chk("frz_inflight_idx", 32'(lut_idx), 32'd77);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("frz_hold_v", 32'(vctrl_mv), 32'd1226);
            chk("frz_hold_pulse", 32'({vctrl_valid, idx_valid}), 32'd0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("post_frz_v", 32'(vctrl_mv), 32'd1226);
        chk("post_frz_vvalid", 32'(vctrl_valid), 32'd1);

        // Reset while an idx computation is pending
        rst = 1'b1;
        tick();
        chk("midrst_v", 32'(vctrl_mv), 32'd1200);
        chk("midrst_idx", 32'(lut_idx), 32'd79);
        chk("midrst_lock", 32'(locked), 32'd0);
        chk("midrst_pulse", 32'({vctrl_valid, idx_valid}), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("midrst_ivalid", 32'(idx_valid), 32'd0);
        chk("midrst_idx2", 32'(lut_idx), 32'd79);

        // Upper saturation and anti-windup recovery
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7000; i++) tick();
        chk("sat_hi_v", 32'(vctrl_mv), 32'd2000);
        chk("sat_hi_idx", 32'(lut_idx), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("hi_dn_v", 32'(vctrl_mv), 32'd1979);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("hi_dn_idx", 32'(lut_idx), 32'd2);

        // Lower saturation
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7000; i++) tick();
        chk("sat_lo_v", 32'(vctrl_mv), 32'd400);
        chk("sat_lo_idx", 32'(lut_idx), 32'd159);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("lo_ud_v", 32'(vctrl_mv), 32'd400);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lo_ud_idx", 32'(lut_idx), 32'd159);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
